img_frame_sched: RTL and testbench



---
 rtl/img_frame_sched.sv | 194 +++++++++++++++++++
 tb/tb_img_frame_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/img_frame_sched.sv
// img_frame_sched
// Replays one stored source image (or back-to-back frames) from the image
// ROM. Generates raster-order read enables/addresses plus VGA-style
// hsync/vsync/de delayed so they line up with the ROM's 1-cycle read data.
// Reports every completed frame with a pulse and a wrapping 16-bit count.
module img_frame_sched #(
   parameter int H_DISP  = 500,
   parameter int V_DISP  = 500,
   parameter int H_SYNC  = 4,
   parameter int H_BACK  = 4,
   parameter int H_FRONT = 4,
   parameter int V_SYNC  = 2,
   parameter int V_BACK  = 2,
   parameter int V_FRONT = 2,
   parameter int ADDR_W  = 18
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cont,
   output logic              busy,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              img_hsync,
   output logic              img_vsync,
   output logic              img_de,
   output logic              frame_done,
   output logic [15:0]       frame_cnt
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
   localparam int HC_W    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int VC_W    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

   // Counter decode points, sized to the counters so compares stay width-clean
   localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
   localparam logic [HC_W-1:0] H_SYNC_END = HC_W'(H_SYNC);
   localparam logic [HC_W-1:0] H_ACT_BEG  = HC_W'(H_SYNC + H_BACK);
   localparam logic [HC_W-1:0] H_ACT_END  = HC_W'(H_SYNC + H_BACK + H_DISP);
   localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
   localparam logic [VC_W-1:0] V_SYNC_END = VC_W'(V_SYNC);
   localparam logic [VC_W-1:0] V_ACT_BEG  = VC_W'(V_SYNC + V_BACK);
   localparam logic [VC_W-1:0] V_ACT_END  = VC_W'(V_SYNC + V_BACK + V_DISP);

   // Idle levels of the output timing bits: {de, vsync, hsync}
   localparam logic [2:0] SYNC_IDLE = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [HC_W-1:0]   h_cnt_reg, h_cnt_next;
   logic [VC_W-1:0]   v_cnt_reg, v_cnt_next;
   logic              frame_start;
   logic              frame_end;
   logic              at_last;
   logic              in_run;
   logic              h_act, v_act, pix_act;
   logic              hs_raw, vs_raw;
   logic [ADDR_W-1:0] pix_cnt_reg;
   logic              hs1_reg, vs1_reg;
   logic [2:0]        stage1_vec;
   logic [2:0]        sync2_reg;

   assign in_run  = (state_reg == ST_RUN);
   assign at_last = (h_cnt_reg == H_LAST) && (v_cnt_reg == V_LAST);
   assign busy    = (state_reg != ST_IDLE);

   // Raster decode of the current counter position
   assign h_act   = (h_cnt_reg >= H_ACT_BEG) && (h_cnt_reg < H_ACT_END);
   assign v_act   = (v_cnt_reg >= V_ACT_BEG) && (v_cnt_reg < V_ACT_END);
   assign pix_act = in_run && h_act && v_act;
   assign hs_raw  = !(in_run && (h_cnt_reg < H_SYNC_END));
   assign vs_raw  = !(in_run && (v_cnt_reg < V_SYNC_END));

   // State and raster counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         h_cnt_reg <= h_cnt_next;
         v_cnt_reg <= v_cnt_next;
      end
   end

   // Next-state and counter stepping; counters sit at (0,0) outside RUN
   always_comb begin
      state_next  = state_reg;
      h_cnt_next  = h_cnt_reg;
      v_cnt_next  = v_cnt_reg;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next  = ST_RUN;
               h_cnt_next  = '0;
               v_cnt_next  = '0;
               frame_start = 1'b1;
            end
         end
         ST_RUN: begin
            if (at_last) begin
               // Leaving the final raster position completes the frame;
               // cont decides between a seamless restart and stopping.
               frame_end  = 1'b1;
               h_cnt_next = '0;
               v_cnt_next = '0;
               if (cont) begin
                  frame_start = 1'b1;
               end else begin
                  state_next = ST_DONE;
               end
            end else if (h_cnt_reg == H_LAST) begin
               h_cnt_next = '0;
               v_cnt_next = v_cnt_reg + 1'b1;
            end else begin
               h_cnt_next = h_cnt_reg + 1'b1;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Stage 1: ROM read strobe/address and raw syncs from the counter decode.
   // rd_addr holds the last issued address between pixels so it never runs
   // past the final pixel index of the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en       <= 1'b0;
         rd_addr     <= '0;
         pix_cnt_reg <= '0;
         hs1_reg     <= 1'b1;
         vs1_reg     <= 1'b1;
      end else begin
         rd_en   <= pix_act;
         hs1_reg <= hs_raw;
         vs1_reg <= vs_raw;
         if (frame_start) begin
            pix_cnt_reg <= '0;
            rd_addr     <= '0;
         end else if (pix_act) begin
            pix_cnt_reg <= pix_cnt_reg + 1'b1;
            rd_addr     <= pix_cnt_reg;
         end
      end
   end

   assign stage1_vec = {rd_en, vs1_reg, hs1_reg};

   // Stage 2: one more flop per timing bit so it coincides with ROM data
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_stage2
         // Delay flop for one timing bit, resetting to its inactive level
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync2_reg[gi] <= SYNC_IDLE[gi];
            end else begin
               sync2_reg[gi] <= stage1_vec[gi];
            end
         end
      end
   endgenerate

   assign img_hsync = sync2_reg[0];
   assign img_vsync = sync2_reg[1];
   assign img_de    = sync2_reg[2];

   // Frame completion pulse and wrapping completed-frame counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         frame_done <= frame_end;
         if (frame_end) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_img_frame_sched.sv
// tb_img_frame_sched
// Small-geometry bench (4x3 active, all porches/syncs 1 => 7x6, 42-cycle
// frame). Expected read addresses, read cycles, data-enable cycles and
// frame_done cycles are queued when a start is driven and popped by a
// negedge monitor as the DUT produces them.
module tb_img_frame_sched;

   localparam int HT   = 7;
   localparam int FR   = 42;
   localparam int LAT1 = 18;   // start-drive edge -> first rd_en
   localparam int LATD = 43;   // start-drive edge -> frame_done

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        cont = 1'b0;
   logic        busy, rd_en, img_hsync, img_vsync, img_de, frame_done;
   logic [3:0]  rd_addr;
   logic [15:0] frame_cnt;

   always #5 clk = ~clk;

   img_frame_sched #(
      .H_DISP(4), .V_DISP(3),
      .H_SYNC(1), .H_BACK(1), .H_FRONT(1),
      .V_SYNC(1), .V_BACK(1), .V_FRONT(1),
      .ADDR_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
      .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr),
      .img_hsync(img_hsync), .img_vsync(img_vsync), .img_de(img_de),
      .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int addr;
      int at;
   } rd_exp_t;

   rd_exp_t addr_q[$];
   int      de_q[$];
   int      done_q[$];

   int rd_cnt, de_cnt, done_cnt, hs_cnt, vs_cnt, busy_cnt, first_vs;
   bit mon_en = 1'b0;
   int fc_model = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor: pops expectations as the DUT produces output
   always @(negedge clk) begin
      if (mon_en) begin
         if (busy) busy_cnt++;
         if (!img_hsync) hs_cnt++;
         if (!img_vsync) begin
            vs_cnt++;
            if (first_vs < 0) first_vs = cyc;
         end
         if (rd_en) begin
            rd_exp_t e;
            rd_cnt++;
            chk("rd_en_expected", 32'(addr_q.size() > 0), 1);
            if (addr_q.size() > 0) begin
               e = addr_q.pop_front();
               chk("rd_addr", rd_addr, e.addr);
               chk("rd_en_cycle", cyc, e.at);
               $display("rd   cyc=%0d addr=%0d", cyc, rd_addr);
            end
            de_q.push_back(cyc + 1);
         end
         if (img_de) begin
            de_cnt++;
            chk("de_sync_overlap", {img_hsync, img_vsync}, 2'b11);
            chk("img_de_expected", 32'(de_q.size() > 0), 1);
            if (de_q.size() > 0) chk("img_de_cycle", cyc, de_q.pop_front());
         end
         if (frame_done) begin
            done_cnt++;
            chk("frame_done_expected", 32'(done_q.size() > 0), 1);
            if (done_q.size() > 0) chk("frame_done_cycle", cyc, done_q.pop_front());
            $display("done cyc=%0d frame_cnt=%0d", cyc, frame_cnt);
         end
      end
   end

   // Queue expectations for n frames started at edge es
   task automatic push_frames(input int n, input int es);
      rd_exp_t e;
      for (int k = 0; k < n; k++) begin
         for (int l = 0; l < 3; l++) begin
            for (int x = 0; x < 4; x++) begin
               e.addr = l * 4 + x;
               e.at   = es + LAT1 + FR * k + HT * l + x;
               addr_q.push_back(e);
            end
         end
         done_q.push_back(es + LATD + FR * k);
      end
   endtask

   // Drive one run of n frames; extra = spurious starts in RUN and DONE
   task automatic run_frames(input int n, input bit extra, output int es);
      rd_cnt = 0; de_cnt = 0; done_cnt = 0; hs_cnt = 0; vs_cnt = 0;
      busy_cnt = 0; first_vs = -1;
      @(posedge clk); #1;
      es = cyc;
      push_frames(n, es);
      for (int o = 0; o <= FR * n + 6; o++) begin
         start = (o == 0) || (extra && (o == 10 || o == 30 || o == FR * n + 1));
         if (o == 0) cont = (n > 1);
         if (o == FR * (n - 1) + 1) cont = 1'b0;
         @(posedge clk); #1;
      end
      start = 1'b0;
      fc_model = (fc_model + n) & 16'hFFFF;
   endtask

   typedef struct {
      int n;
      bit extra;
      int exp_rd;
      int exp_done;
      int exp_busy;
      int exp_hs;
      int exp_vs;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int es;
      bit found;

      vecs[0] = '{n: 1, extra: 1'b0, exp_rd: 12, exp_done: 1, exp_busy: 43,  exp_hs: 6,  exp_vs: 7};
      vecs[1] = '{n: 3, extra: 1'b0, exp_rd: 36, exp_done: 3, exp_busy: 127, exp_hs: 18, exp_vs: 21};
      vecs[2] = '{n: 1, extra: 1'b1, exp_rd: 12, exp_done: 1, exp_busy: 43,  exp_hs: 6,  exp_vs: 7};
      vecs[3] = '{n: 2, extra: 1'b1, exp_rd: 24, exp_done: 2, exp_busy: 85,  exp_hs: 12, exp_vs: 14};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_hsync", img_hsync, 1);
      chk("rst_vsync", img_vsync, 1);
      chk("rst_de", img_de, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven runs
      for (int v = 0; v < 4; v++) begin
         run_frames(vecs[v].n, vecs[v].extra, es);
         chk("rd_count", rd_cnt, vecs[v].exp_rd);
         chk("de_count", de_cnt, vecs[v].exp_rd);
         chk("done_count", done_cnt, vecs[v].exp_done);
         chk("busy_cycles", busy_cnt, vecs[v].exp_busy);
         chk("hsync_low_cycles", hs_cnt, vecs[v].exp_hs);
         chk("vsync_low_cycles", vs_cnt, vecs[v].exp_vs);
         chk("vsync_first_cycle", first_vs, es + 3);
         chk("frame_cnt", frame_cnt, fc_model);
         chk("busy_after", busy, 0);
         chk("rd_queue_drained", addr_q.size(), 0);
         chk("done_queue_drained", done_q.size(), 0);
         $display("vec %0d frames=%0d extra=%0d rd=%0d done=%0d frame_cnt=%0d",
                  v, vecs[v].n, vecs[v].extra, rd_cnt, done_cnt, frame_cnt);
      end

      // Mid-frame reset at rd_addr 5
      @(posedge clk); #1;
      es = cyc;
      push_frames(1, es);
      start = 1'b1; cont = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (rd_en && rd_addr == 4'd5) found = 1'b1;
      end
      chk("reached_addr5", found, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_rd_en", rd_en, 0);
      chk("mrst_rd_addr", rd_addr, 0);
      chk("mrst_hsync", img_hsync, 1);
      chk("mrst_vsync", img_vsync, 1);
      chk("mrst_de", img_de, 0);
      chk("mrst_frame_done", frame_done, 0);
      chk("mrst_frame_cnt", frame_cnt, 0);
      $display("mid-frame reset cyc=%0d frame_cnt=%0d", cyc, frame_cnt);
      addr_q.delete(); de_q.delete(); done_q.delete();
      fc_model = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_frames(1, 1'b0, es);
      chk("post_rst_rd_count", rd_cnt, 12);
      chk("post_rst_done_count", done_cnt, 1);
      chk("post_rst_frame_cnt", frame_cnt, fc_model);
      chk("post_rst_rd_queue", addr_q.size(), 0);

      // frame_cnt wrap from 0xFFFF
      @(negedge clk);
      force dut.frame_cnt = 16'hFFFF;
      #1 release dut.frame_cnt;
      #1 chk("wrap_preload", frame_cnt, 16'hFFFF);
      fc_model = 16'hFFFF;
      run_frames(1, 1'b0, es);
      chk("wrap_frame_cnt", frame_cnt, fc_model);
      chk("wrap_to_zero", frame_cnt, 0);
      $display("wrap frame_cnt=%0d", frame_cnt);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

endmodule
